// File: rtl/rate_counter_pkg.sv
// Shared constants for rate_counter: speed-select and direction encodings and the
// default 50 MHz board-clock tick periods.
package rate_counter_pkg;

    localparam logic [1:0] SPD_FAST    = 2'd0;
    localparam logic [1:0] SPD_1HZ     = 2'd1;
    localparam logic [1:0] SPD_HALF    = 2'd2;
    localparam logic [1:0] SPD_QUARTER = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned PERIOD_FAST_DEFAULT    = 1;
    localparam int unsigned PERIOD_1HZ_DEFAULT     = 50_000_000;
    localparam int unsigned PERIOD_HALF_DEFAULT    = 100_000_000;
    localparam int unsigned PERIOD_QUARTER_DEFAULT = 200_000_000;

endpackage

// File: rtl/rate_counter_tick_divider.sv
// Selectable-period tick divider: counts down from PERIODsel-1 and ticks at zero.
// A speed change restarts the period and suppresses the tick for that cycle.
module tick_divider
    import rate_counter_pkg::*;
#(
    parameter int unsigned DIV_W   = 28,
    parameter int unsigned PERIOD0 = PERIOD_FAST_DEFAULT,
    parameter int unsigned PERIOD1 = PERIOD_1HZ_DEFAULT,
    parameter int unsigned PERIOD2 = PERIOD_HALF_DEFAULT,
    parameter int unsigned PERIOD3 = PERIOD_QUARTER_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] speed_sel,
    output logic       tick
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             same_sel;
    logic             div_zero;

    function automatic logic [DIV_W-1:0] reload_value(input logic [1:0] sel);
        logic [DIV_W-1:0] value;
        unique case (sel)
            SPD_FAST:    value = DIV_W'(PERIOD0 - 1);
            SPD_1HZ:     value = DIV_W'(PERIOD1 - 1);
            SPD_HALF:    value = DIV_W'(PERIOD2 - 1);
            SPD_QUARTER: value = DIV_W'(PERIOD3 - 1);
        endcase
        return value;
    endfunction

    always_comb begin
        same_sel  = (speed_sel == sel_q);
        div_zero  = (div_cnt_q == '0);
        // Gated by reset so no tick leaks out while reset is held.
        tick      = reset & run & same_sel & div_zero;
        div_cnt_d = div_cnt_q;
        sel_d     = sel_q;
        if (!same_sel) begin
            div_cnt_d = reload_value(speed_sel);
            sel_d     = speed_sel;
        end else if (run) begin
            div_cnt_d = div_zero ? reload_value(sel_q) : div_cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt_q <= '0;
            sel_q     <= speed_sel;
        end else begin
            div_cnt_q <= div_cnt_d;
            sel_q     <= sel_d;
        end
    end

endmodule

// File: rtl/rate_counter.sv
// Modulo display counter advanced by a selectable-rate tick, with load and wrap pulse.
// Define RATE_COUNTER_DOWN_EN to honour dir; otherwise the counter only counts up.
module rate_counter
    import rate_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16,
    parameter int unsigned DIV_W   = 28,
    parameter int unsigned PERIOD0 = PERIOD_FAST_DEFAULT,
    parameter int unsigned PERIOD1 = PERIOD_1HZ_DEFAULT,
    parameter int unsigned PERIOD2 = PERIOD_HALF_DEFAULT,
    parameter int unsigned PERIOD3 = PERIOD_QUARTER_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       speed_sel,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    tick_divider #(
        .DIV_W   (DIV_W),
        .PERIOD0 (PERIOD0),
        .PERIOD1 (PERIOD1),
        .PERIOD2 (PERIOD2),
        .PERIOD3 (PERIOD3)
    ) u_tick_divider (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

`ifndef RATE_COUNTER_DOWN_EN
    logic unused_dir;
    assign unused_dir = dir;
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_value > MaxCount) ? MaxCount : load_value;
        end else if (tick) begin
`ifdef RATE_COUNTER_DOWN_EN
            if (dir == DIR_DOWN) begin
                wrap_d  = (count_q == '0);
                count_d = wrap_d ? MaxCount : count_q - WIDTH'(1);
            end else
`endif
            begin
                wrap_d  = (count_q == MaxCount);
                count_d = wrap_d ? '0 : count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: doc/rate_counter.md
# rate_counter

Parametrised modulo counter advanced by a selectable-rate tick, for driving slow visible displays (HEX digits, LEDs) from the 50 MHz board clock. Generalises the fixed 4-bit up-counter with four speeds: configurable width, modulus and periods, exact divide-by-N, up/down counting, run/pause, synchronous load, and a wrap pulse for cascading digits. It sits between board switches/keys and a hex-display decoder.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- DIV_W, 28: divider counter width.
- PERIOD0, 1: tick period in clocks for speed_sel=0 (1 → every clock).
- PERIOD1, 50_000_000: period for speed_sel=1 (1 Hz at 50 MHz).
- PERIOD2, 100_000_000: period for speed_sel=2.
- PERIOD3, 200_000_000: period for speed_sel=3. Every PERIODn satisfies 1 ≤ PERIODn ≤ 2^DIV_W.
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  1 = divider runs and ticks advance the count; 0 = everything holds.
- speed_sel  in  2  selects PERIOD0..PERIOD3.
- dir  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load; clamped to MODULUS-1 if larger.
- count  out  WIDTH  current count, registered.
- tick  out  1  divider tick, combinational from divider state and run.
- wrap  out  1  registered one-cycle pulse, high in the cycle count shows a wrapped value.

## Operation
- Reset (reset=0 at an edge): count=0, wrap=0, divider=0, sel_q=speed_sel. tick is 0 while reset is held.
- Divider: tick = run & (div_cnt==0) & (speed_sel==sel_q). When div_cnt==0 with run=1, reload PERIODsel-1; otherwise, with run=1, decrement. run=0 holds div_cnt.
- Speed change (speed_sel≠sel_q): div_cnt ← PERIODnew-1, sel_q ← speed_sel, no tick that cycle. This applies regardless of run.
- Count update on an edge, in priority order:
  1. load=1: count ← min(load_value, MODULUS-1); wrap ← 0. Load works even with run=0.
  2. tick=1, dir=1: count ← (count==MODULUS-1) ? 0 : count+1; wrap ← (count==MODULUS-1).
  3. tick=1, dir=0: count ← (count==0) ? MODULUS-1 : count-1; wrap ← (count==0).
  4. Otherwise count holds and wrap ← 0.
- Arithmetic is on WIDTH bits, with the wrap compare done before the increment or decrement. count never leaves 0..MODULUS-1.
- Reset mid-operation overrides load and tick in the same cycle.

## Timing
- With run=1 held and speed_sel stable from reset release, tick is high in the first cycle, then exactly every PERIODsel cycles.
- count changes one cycle after tick (at the edge closing the tick cycle).
- wrap coincides with the wrapped count value and lasts exactly one cycle.
- PERIOD0=1 gives tick every cycle, and count advances every clock.
- The first tick after a speed change occurs PERIODnew cycles after the change cycle.

## Configuration
- RATE_COUNTER_DOWN_EN defined: dir is honoured as above.
- Not defined: dir is ignored and the block counts up only; rule 3 logic is not synthesised.
- The dir port exists in both builds.

## Structure
- Package rate_counter_pkg:
  - speed-select encoding constants SPD_FAST=0, SPD_1HZ=1, SPD_HALF=2, SPD_QUARTER=3;
  - DIR_UP=1, DIR_DOWN=0;
  - the default 50 MHz period constants.
- Sub-module tick_divider (parameters DIV_W, PERIOD0..3; ports clock, reset, run, speed_sel, tick) owns div_cnt, sel_q and the tick.
- rate_counter holds the count/wrap register and the priority logic.

## Test plan
- PERIOD0..3 overridden to 1,3,5,8; MODULUS=10, run=1, speed_sel=1, dir=1 → tick every 3 cycles; count 0,1,…,9,0; wrap high only in the cycle count returns to 0.
- speed_sel=0 → count advances every clock. Change to speed_sel=3 mid-period → no tick in the change cycle, next tick 8 cycles later.
- RATE_COUNTER_DOWN_EN defined, dir=0 from count=0 → next tick gives count=9 with wrap=1. Without the macro, the same stimulus gives count=1, wrap=0.
- load=1, load_value=13 (MODULUS=10), coinciding with a tick → count=9, wrap=0. load with run=0 → count=load_value.
- run=0 for 20 cycles mid-period → count, tick and divider frozen. On run=1 the remaining period resumes, with no extra or lost tick.
- reset=0 asserted for 1 cycle at count=7 while tick=1 → count=0, wrap=0. Ticks restart on the first post-reset cycle.
